// File: rtl/i2c_regbank_pkg.sv
// Shared types and constants for the I2C/host register bank arbiter.
package i2c_regbank_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    // Addresses below this limit are read-only from I2C when write protection is built in.
    localparam int unsigned WPROT_LIMIT   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StI2cWr,
        StI2cRd,
        StHost
    } arb_state_e;

    function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned depth);
        return {24'd0, addr} < depth;
    endfunction

endpackage

// File: rtl/i2c_regbank_arbiter_if.sv
// Bus bundle between the I2C slave front-end, the host and the register bank arbiter.
import i2c_regbank_pkg::*;

interface i2c_regbank_arbiter_if #(
    parameter int unsigned HOST_AW = $clog2(DEFAULT_DEPTH)
);
    logic               i2c_rw;
    logic [7:0]         i2c_addr;
    logic               i2c_wen;
    logic [7:0]         i2c_wdata;
    logic               i2c_rdata_used;
    logic [7:0]         i2c_rdata;
    logic               host_req;
    logic               host_we;
    logic [HOST_AW-1:0] host_addr;
    logic [7:0]         host_wdata;
    logic               host_gnt;
    logic [7:0]         host_rdata;
    logic               host_rvalid;
    logic               ovf;

    modport slave (
        input  i2c_rw, i2c_addr, i2c_wen, i2c_wdata, i2c_rdata_used,
        input  host_req, host_we, host_addr, host_wdata,
        output i2c_rdata, host_gnt, host_rdata, host_rvalid, ovf
    );

    modport master (
        output i2c_rw, i2c_addr, i2c_wen, i2c_wdata, i2c_rdata_used,
        output host_req, host_we, host_addr, host_wdata,
        input  i2c_rdata, host_gnt, host_rdata, host_rvalid, ovf
    );

endinterface

// File: rtl/regbank_sp.sv
// Single-port byte register bank: one access per cycle, synchronous write, registered read.
module regbank_sp #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
            rdata <= 8'h00;
        end else if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/i2c_regbank_arbiter.sv
// Arbitrates one single-port register bank between an I2C slave and a host port.
// Build option: define I2C_REGBANK_WPROT_EN to make the low addresses read-only from I2C.
module i2c_regbank_arbiter
    import i2c_regbank_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned HOST_AW = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  rst,
    i2c_regbank_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    logic       last_host_q, last_host_d;

    logic       pend_q, pend_d;
    logic [7:0] pend_addr_q, pend_addr_d;
    logic [7:0] pend_data_q, pend_data_d;
    logic       ovf_q, ovf_d;
    logic       host_pend_q, host_pend_d;

    logic       stale_q, stale_d;
    logic [7:0] fetch_addr_q, fetch_addr_d;
    logic       fill_q, fill_oor_q;
    logic [7:0] i2c_rdata_q, i2c_rdata_int;
    logic       rvalid_q;

    logic               bank_en, bank_we;
    logic [HOST_AW-1:0] bank_addr;
    logic [7:0]         bank_wdata, bank_rdata;

    logic i2c_in_range, pend_in_range, fetch_in_range, pend_wprot;
    logic wr_hit, wr_rq, rd_rq, host_rq, drain;
    logic unused_rw;

    assign unused_rw      = bus.i2c_rw;
    assign i2c_in_range   = addr_in_range(bus.i2c_addr, DEPTH);
    assign pend_in_range  = addr_in_range(pend_addr_q, DEPTH);
    assign fetch_in_range = addr_in_range(fetch_addr_q, DEPTH);

`ifdef I2C_REGBANK_WPROT_EN
    assign pend_wprot = {24'd0, pend_addr_q} < WPROT_LIMIT;
`else
    assign pend_wprot = 1'b0;
`endif

    // Bank port is owned by whichever slot is active this cycle.
    always_comb begin
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = bus.host_addr;
        bank_wdata = bus.host_wdata;
        unique case (state_q)
            StI2cWr: begin
                bank_addr  = pend_addr_q[HOST_AW-1:0];
                bank_wdata = pend_data_q;
                bank_en    = pend_in_range & ~pend_wprot;
                bank_we    = pend_in_range & ~pend_wprot;
            end
            StI2cRd: begin
                bank_addr = bus.i2c_addr[HOST_AW-1:0];
                bank_en   = i2c_in_range;
            end
            StHost: begin
                bank_en = 1'b1;
                bank_we = bus.host_we;
            end
            default: ;
        endcase
    end

    assign wr_hit = bank_we & fetch_in_range & (bank_addr == fetch_addr_q[HOST_AW-1:0]);

    // Pending I2C write buffer; a write arriving while it is full and not draining is lost.
    always_comb begin
        drain       = (state_q == StI2cWr);
        pend_d      = pend_q & ~drain;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        if (bus.i2c_wen) begin
            if (pend_d) begin
                ovf_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = bus.i2c_addr;
                pend_data_d = bus.i2c_wdata;
            end
        end
        host_pend_d = bus.host_req & (state_q != StHost);
    end

    // Slot scheduling for the next cycle; requests are judged as they stand after this slot.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (state_q == StI2cRd) begin
            fetch_addr_d = bus.i2c_addr;
            stale_d      = bus.i2c_rdata_used;
        end else begin
            stale_d = stale_q | (bus.i2c_addr != fetch_addr_q) | bus.i2c_rdata_used | wr_hit;
        end

        wr_rq   = pend_q & (state_q != StI2cWr);
        host_rq = host_pend_q & (state_q != StHost);
        rd_rq   = stale_d;

        state_d     = StIdle;
        last_host_d = last_host_q;
        if (wr_rq) begin
            state_d = StI2cWr;
        end else if (rd_rq && (!host_rq || last_host_q)) begin
            state_d     = StI2cRd;
            last_host_d = 1'b0;
        end else if (host_rq) begin
            state_d     = StHost;
            last_host_d = 1'b1;
        end
    end

    // The registered bank read lands one cycle after an I2C_RD slot; pass it straight through.
    assign i2c_rdata_int = fill_q ? (fill_oor_q ? 8'h00 : bank_rdata) : i2c_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_host_q  <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= 8'h00;
            pend_data_q  <= 8'h00;
            ovf_q        <= 1'b0;
            host_pend_q  <= 1'b0;
            stale_q      <= 1'b1;
            fetch_addr_q <= 8'h00;
            fill_q       <= 1'b0;
            fill_oor_q   <= 1'b0;
            i2c_rdata_q  <= 8'h00;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_host_q  <= last_host_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            ovf_q        <= ovf_d;
            host_pend_q  <= host_pend_d;
            stale_q      <= stale_d;
            fetch_addr_q <= fetch_addr_d;
            fill_q       <= (state_q == StI2cRd);
            fill_oor_q   <= ~i2c_in_range;
            i2c_rdata_q  <= i2c_rdata_int;
            rvalid_q     <= (state_q == StHost) & ~bus.host_we;
        end
    end

    regbank_sp #(
        .DEPTH (DEPTH),
        .AW    (HOST_AW)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (bank_en),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    assign bus.i2c_rdata   = i2c_rdata_int;
    assign bus.host_gnt    = (state_q == StHost);
    assign bus.host_rdata  = bank_rdata;
    assign bus.host_rvalid = rvalid_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_i2c_regbank_arbiter.sv
// Directed bench for i2c_regbank_arbiter; host read results go through an expected-value queue.
module tb_i2c_regbank_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    i2c_regbank_arbiter_if #(.HOST_AW(4)) bus ();

    i2c_regbank_arbiter #(
        .DEPTH   (16),
        .HOST_AW (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef I2C_REGBANK_WPROT_EN
    localparam logic [7:0] EXP_WP = 8'h00;
`else
    localparam logic [7:0] EXP_WP = 8'hFF;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];
    int         w;
    logic       ok;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic i2c_write(input logic [7:0] a, input logic [7:0] d);
        bus.i2c_addr  = a;
        bus.i2c_wdata = d;
        bus.i2c_wen   = 1'b1;
        step();
        bus.i2c_wen = 1'b0;
        step(3);
    endtask

    task automatic i2c_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.i2c_addr = a;
        step(3);
        check(tag, bus.i2c_rdata, exp);
    endtask

    task automatic host_xfer(input string tag, input logic we, input logic [3:0] a,
                             input logic [7:0] d, input logic [7:0] exp);
        int n;
        logic [7:0] e;
        if (!we) exp_q.push_back(exp);
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_req   = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.host_gnt && n < 12);
        check({tag, "_gnt"}, {7'd0, bus.host_gnt}, 8'd1);
        step();
        bus.host_req = 1'b0;
        check({tag, "_gnt_pulse"}, {7'd0, bus.host_gnt}, 8'd0);
        if (!we) begin
            check({tag, "_rvalid"}, {7'd0, bus.host_rvalid}, 8'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_rdata"}, bus.host_rdata, e);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst                = 1'b1;
        bus.i2c_rw         = 1'b0;
        bus.i2c_addr       = 8'h00;
        bus.i2c_wen        = 1'b0;
        bus.i2c_wdata      = 8'h00;
        bus.i2c_rdata_used = 1'b0;
        bus.host_req       = 1'b0;
        bus.host_we        = 1'b0;
        bus.host_addr      = 4'h0;
        bus.host_wdata     = 8'h00;
        step(3);
        check("rst_i2c_rdata", bus.i2c_rdata, 8'h00);
        check("rst_host_gnt", {7'd0, bus.host_gnt}, 8'd0);
        check("rst_host_rvalid", {7'd0, bus.host_rvalid}, 8'd0);
        check("rst_host_rdata", bus.host_rdata, 8'h00);
        check("rst_ovf", {7'd0, bus.ovf}, 8'd0);
        rst = 1'b0;
        step(2);

        // I2C write then host read back
        i2c_write(8'h05, 8'hA5);
        host_xfer("host_rd5", 1'b0, 4'h5, 8'h00, 8'hA5);

        // Host write seen by I2C prefetch, then refreshed by a host write to the fetched address
        host_xfer("host_wr3", 1'b1, 4'h3, 8'h3C, 8'h00);
        i2c_read("i2c_rd3", 8'h03, 8'h3C);
        host_xfer("host_wr3b", 1'b1, 4'h3, 8'h5A, 8'h00);
        step(3);
        check("i2c_rd3_refresh", bus.i2c_rdata, 8'h5A);
        check("ovf_clear", {7'd0, bus.ovf}, 8'd0);

        // Back-to-back I2C writes: the second is dropped and ovf sticks
        bus.i2c_addr  = 8'h08;
        bus.i2c_wdata = 8'h11;
        bus.i2c_wen   = 1'b1;
        step();
        bus.i2c_addr  = 8'h09;
        bus.i2c_wdata = 8'h22;
        step();
        bus.i2c_wen = 1'b0;
        step();
        check("ovf_set", {7'd0, bus.ovf}, 8'd1);
        step(2);
        host_xfer("ovf_kept", 1'b0, 4'h8, 8'h00, 8'h11);
        host_xfer("ovf_drop", 1'b0, 4'h9, 8'h00, 8'h00);

        // Host request during continuous prefetch churn
        exp_q.push_back(8'h5A);
        bus.host_we   = 1'b0;
        bus.host_addr = 4'h3;
        bus.host_req  = 1'b1;
        w = 0;
        do begin
            bus.i2c_addr       = (w % 2 == 0) ? 8'h04 : 8'h05;
            bus.i2c_rdata_used = 1'b1;
            step();
            w++;
        end while (!bus.host_gnt && w < 12);
        bus.i2c_rdata_used = 1'b0;
        ok = (w <= 3);
        check("churn_gnt_bound", {7'd0, ok}, 8'd1);
        step();
        bus.host_req = 1'b0;
        check("churn_rvalid", {7'd0, bus.host_rvalid}, 8'd1);
        check("churn_rdata", bus.host_rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx);
        step(2);

        // Low-address write protection (build dependent)
        i2c_write(8'h02, 8'hFF);
        host_xfer("wprot", 1'b0, 4'h2, 8'h00, EXP_WP);

        // Out-of-range I2C reads return zero; out-of-range writes are ignored
        i2c_read("i2c_rd5", 8'h05, 8'hA5);
        i2c_read("i2c_rd_oor", 8'h20, 8'h00);
        i2c_write(8'h25, 8'h77);
        host_xfer("oor_wr_ignored", 1'b0, 4'h5, 8'h00, 8'hA5);

        // Simultaneous I2C and host writes to one address: host value survives
        bus.i2c_addr   = 8'h06;
        bus.i2c_wdata  = 8'h11;
        bus.i2c_wen    = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 4'h6;
        bus.host_wdata = 8'h99;
        bus.host_req   = 1'b1;
        step();
        bus.i2c_wen = 1'b0;
        w = 0;
        while (!bus.host_gnt && w < 12) begin
            step();
            w++;
        end
        check("same_addr_gnt", {7'd0, bus.host_gnt}, 8'd1);
        step();
        bus.host_req = 1'b0;
        step(3);
        check("same_addr_i2c_view", bus.i2c_rdata, 8'h99);
        host_xfer("same_addr_host", 1'b0, 4'h6, 8'h00, 8'h99);

        // Reset during a host write grant: nothing committed, outputs cleared
        bus.host_we    = 1'b1;
        bus.host_addr  = 4'h7;
        bus.host_wdata = 8'hEE;
        bus.host_req   = 1'b1;
        w = 0;
        do begin
            step();
            w++;
        end while (!bus.host_gnt && w < 12);
        check("rstmid_gnt", {7'd0, bus.host_gnt}, 8'd1);
        rst          = 1'b1;
        bus.host_req = 1'b0;
        #1;
        check("rstmid_i2c_rdata", bus.i2c_rdata, 8'h00);
        check("rstmid_host_gnt", {7'd0, bus.host_gnt}, 8'd0);
        check("rstmid_host_rvalid", {7'd0, bus.host_rvalid}, 8'd0);
        check("rstmid_host_rdata", bus.host_rdata, 8'h00);
        check("rstmid_ovf", {7'd0, bus.ovf}, 8'd0);
        step(2);
        rst = 1'b0;
        step(2);
        host_xfer("rstmid_no_commit", 1'b0, 4'h7, 8'h00, 8'h00);
        host_xfer("rstmid_bank_clear", 1'b0, 4'h5, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_regbank_arbiter.md
I2C_REGBANK_ARBITER -- requirements
Module: i2c_regbank_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 8-bit registers (power of two, 4..256).
REQ-002 SHALL have parameter HOST_AW, default 4, host address width, equal to log2(DEPTH).
REQ-003 SHALL have these ports: clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port i2c_rw  in  1  I2C slave transaction direction, 1=read.
REQ-006 SHALL have port i2c_addr  in  8  I2C slave application address.
REQ-007 SHALL have port i2c_wen  in  1  one-cycle write strobe.
REQ-008 SHALL have port i2c_wdata  in  8  write data.
REQ-009 SHALL have port i2c_rdata_used  in  1  one-cycle pulse; current i2c_rdata consumed.
REQ-010 SHALL have port i2c_rdata  out  8  prefetched read data for i2c_addr.
REQ-011 SHALL have port host_req  in  1  host access request, held until granted.
REQ-012 SHALL have port host_we  in  1  host write, 1=write.
REQ-013 SHALL have port host_addr  in  HOST_AW  host register address.
REQ-014 SHALL have port host_wdata  in  8  host write data.
REQ-015 SHALL have port host_gnt  out  1  one-cycle grant; access is performed this cycle.
REQ-016 SHALL have port host_rdata  out  8  host read data.
REQ-017 SHALL have port host_rvalid  out  1  one-cycle strobe, host_rdata valid.
REQ-018 SHALL have port ovf  out  1  sticky flag, I2C write lost.

Function
REQ-019 SHALL own one single-port DEPTH x 8 register bank that permits one access (read or write) per clk cycle.
REQ-020 SHALL capture each i2c_wen pulse, with its address and data, into a 1-deep pending-write buffer.
REQ-021 SHALL set ovf when i2c_wen arrives while the buffer is full and not being drained this cycle; the new write is dropped and the old one is kept.
REQ-022 SHALL mark i2c_rdata stale on any of: i2c_addr differing from the last fetched address, i2c_rdata_used, or any bank write to the fetched address.
REQ-023 SHALL grant one bank slot per cycle; the FSM states are IDLE, I2C_WR, I2C_RD and HOST.
REQ-024 SHALL use this grant priority: pending I2C write first, then stale-prefetch refresh and host_req round-robin, with the last winner losing a tie.
REQ-025 SHALL, on an I2C_RD slot, load i2c_rdata from bank[i2c_addr] at the end of that cycle and clear the stale mark, unless a new staleness event occurs in the same cycle.
REQ-026 SHALL assert host_gnt for exactly one cycle per serviced request.
REQ-027 SHALL commit a host write at the edge ending the grant cycle.
REQ-028 SHALL present a host read's data on host_rdata with host_rvalid one cycle after the grant.
REQ-029 SHALL ignore I2C writes to i2c_addr >= DEPTH (the buffer still drains) and SHALL return 0x00 for I2C reads at those addresses.
REQ-030 SHALL make an I2C write and a host write to the same address that become pending simultaneously resolve as I2C first, host second, so the host value remains.
REQ-031 SHALL ensure a host request waits at most 3 cycles while I2C traffic is continuous.
REQ-032 SHALL ensure i2c_rdata is valid at most 3 cycles after a staleness event.

Reset
REQ-033 SHALL, on rst, clear the bank to 0x00, set i2c_rdata=0x00, host_rdata=0x00, host_gnt=0, host_rvalid=0 and ovf=0, empty the buffer, mark the prefetch stale and enter IDLE.
REQ-034 SHALL drop any in-flight grant or pending write when rst is asserted mid-operation; no partial write is committed.

Configuration
REQ-035 SHALL support macro I2C_REGBANK_WPROT_EN; when defined, addresses 0..3 are read-only from I2C, and writes there drain the buffer without modifying the bank.
REQ-036 SHALL, without I2C_REGBANK_WPROT_EN, let all addresses below DEPTH be writable from both ports.

Structure
REQ-037 SHALL place the FSM state enum, default DEPTH and the write-protect boundary constant in package i2c_regbank_pkg.
REQ-038 SHALL implement the bank as sub-module regbank_sp (single port, synchronous write, registered read).

Verification
REQ-039 SHALL cover: i2c_wen addr 0x05 data 0xA5, then host read 0x5 -> host_rvalid with host_rdata 0xA5.
REQ-040 SHALL cover: host write 0x3=0x3C, then i2c_addr set to 0x03 -> i2c_rdata 0x3C within 3 cycles.
REQ-041 SHALL cover: two i2c_wen pulses 1 cycle apart while the buffer is blocked -> ovf=1, first write kept.
REQ-042 SHALL cover: host_req held during continuous prefetch churn -> host_gnt within 3 cycles.
REQ-043 SHALL cover: I2C write to 0x02=0xFF with the macro defined -> bank[2] unchanged (0x00); without the macro -> 0xFF.
REQ-044 SHALL cover: rst asserted during a host grant cycle -> no write committed, all outputs 0.
